// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the MEM stage and a DMA burst engine.
// The CPU wins by default; a starved DMA beat is forced through after MAX_WAIT denied cycles.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic [31:0]      cpu_rdata_o,
  output logic             cpu_stall_o,
  input  logic             dma_req_i,
  input  logic             dma_we_i,
  input  logic [31:0]      dma_addr_i,
  input  logic [LEN_W-1:0] dma_len_i,
  input  logic [31:0]      dma_wdata_i,
  output logic [31:0]      dma_rdata_o,
  output logic             dma_ack_o,
  output logic             dma_done_o,
  output logic             dma_busy_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             mem_wr_o,
  input  logic [31:0]      mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t           state_q, state_d;
  logic [9:0]       base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic             dir_q, dir_d;
  logic [3:0]       wait_q, wait_d;
  logic             grant;
  logic [9:0]       word;
  logic             unused;
  assign unused = ^{dma_addr_i[31:12], dma_addr_i[1:0]};
  assign grant  = (state_q == BURST) && (!cpu_req_i || wait_q == 4'(MAX_WAIT));
  assign word   = base_q + 10'(beat_q);
  assign cpu_rdata_o = mem_rdata_i;
  assign dma_rdata_o = mem_rdata_i;
  assign cpu_stall_o = grant & cpu_req_i;
  assign dma_ack_o   = grant;
  assign dma_done_o  = state_q == DONE;
  assign dma_busy_o  = state_q != IDLE;
  assign mem_addr_o  = grant ? {20'b0, word, 2'b00} : cpu_addr_i;
  assign mem_wdata_o = grant ? dma_wdata_i : cpu_wdata_i;
  // Gated by rst_n so a CPU store presented during reset cannot reach memory.
  assign mem_wr_o    = rst_n & (grant ? dir_q : cpu_req_i & cpu_we_i);
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    dir_d   = dir_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: if (dma_req_i) begin
        state_d = dma_len_i != '0 ? BURST : DONE;
        base_d  = dma_addr_i[11:2];
        len_d   = dma_len_i;
        dir_d   = dma_we_i;
        beat_d  = '0;
        wait_d  = '0;
      end
      BURST: if (grant) begin
        beat_d  = beat_q + LEN_W'(1);
        wait_d  = '0;
        state_d = beat_q == len_q - LEN_W'(1) ? DONE : BURST;
      end else begin
        wait_d  = wait_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural 1024x32 memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
  logic [7:0]  dma_len = '0;
  logic        dma_ack, dma_done, dma_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;
  logic [31:0] mem [1024];
  int total = 0, bad = 0;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] data;} beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_len_i(dma_len),
    .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
    .dma_done_o(dma_done), .dma_busy_o(dma_busy),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_o(mem_wr), .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({cpu_stall, dma_ack, dma_done, dma_busy, mem_wr} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000", {cpu_stall, dma_ack, dma_done, dma_busy, mem_wr});
    end
    total++;
    if (mem[16] !== 32'h0) begin bad++; $display("FAIL reset_no_write got=%h want=0", mem[16]); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_only();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if ({mem_wr, cpu_stall, mem_addr} !== {2'b10, 32'h10}) begin
      bad++; $display("FAIL cpu_store wr=%b stall=%b addr=%h want wr=1 stall=0 addr=10", mem_wr, cpu_stall, mem_addr);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_rdata !== 32'hDEAD_BEEF || cpu_stall !== 1'b0 || mem_wr !== 1'b0) begin
      bad++; $display("FAIL cpu_load rdata=%h stall=%b wr=%b want rdata=deadbeef stall=0 wr=0", cpu_rdata, cpu_stall, mem_wr);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic run_dma(input logic we, input logic [31:0] addr, input int len, input logic hold,
                         input logic cwe, output int acks, output int done_cyc);
    int last;
    logic [9:0] w;
    beat_t e;
    acks = 0; done_cyc = 0; last = 0;
    for (int i = 0; i < len; i++) begin
      w = addr[11:2] + 10'(i);
      e.addr = {20'b0, w, 2'b00}; e.we = we; e.data = we ? 32'hA000_0000 + i : mem[w];
      q.push_back(e);
    end
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_len = 8'(len); dma_wdata = 32'hA000_0000;
    cpu_req = hold; cpu_we = cwe; cpu_addr = 32'h100; cpu_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    dma_we = ~we; dma_addr = 32'h300; dma_len = 8'd7;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (dma_ack) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL extra_ack cycle=%0d got ack=1 want ack=0", c);
        end else begin
          e = q.pop_front();
          if (mem_addr !== e.addr || mem_wr !== e.we || (we ? mem_wdata : dma_rdata) !== e.data || cpu_stall !== hold) begin
            bad++;
            $display("FAIL dma_beat cycle=%0d addr=%h wr=%b data=%h stall=%b want addr=%h wr=%b data=%h stall=%b",
                     c, mem_addr, mem_wr, we ? mem_wdata : dma_rdata, cpu_stall, e.addr, e.we, e.data, hold);
          end
        end
        acks++; last = c;
      end else if (dma_busy && !dma_done) begin
        total++;
        if (cpu_stall !== 1'b0 || mem_addr !== 32'h100 || mem_wr !== (hold & cwe)) begin
          bad++; $display("FAIL cpu_slot cycle=%0d stall=%b addr=%h wr=%b want stall=0 addr=100 wr=%b", c, cpu_stall, mem_addr, mem_wr, hold & cwe);
        end
      end
      if (dma_done) begin done_cyc = c; dma_req = 1'b0; end
      @(posedge clk); #1;
      dma_wdata = 32'hA000_0000 + acks;
    end
    dma_req = 1'b0;
    total++;
    if (done_cyc == 0) begin bad++; $display("FAIL dma_timeout got done=0 want done=1"); end
    total++;
    if (len > 0 && done_cyc !== last + 1) begin
      bad++; $display("FAIL done_after_last done_cycle=%0d want=%0d", done_cyc, last + 1);
    end
    @(negedge clk);
    total++;
    if (dma_done !== 1'b0 || dma_busy !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL done_one_cycle done=%b busy=%b left=%0d want 0 0 0", dma_done, dma_busy, q.size());
    end
    q.delete();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_dma_write();
    int acks, dc;
    run_dma(1'b1, 32'h20, 4, 1'b0, 1'b0, acks, dc);
    total++;
    if (acks != 4 || dc != 5) begin bad++; $display("FAIL write_burst acks=%0d done=%0d want 4 5", acks, dc); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[8+i] !== 32'hA000_0000 + i) begin
        bad++; $display("FAIL write_word%0d got=%h want=%h", 8 + i, mem[8+i], 32'hA000_0000 + i);
      end
    end
  endtask

  task automatic test_starvation();
    int acks, dc;
    for (int i = 0; i < 3; i++) mem[16+i] = 32'hC0DE_0000 + i;
    run_dma(1'b0, 32'h40, 3, 1'b1, 1'b1, acks, dc);
    total++;
    if (acks != 3 || dc != 16) begin bad++; $display("FAIL starve_burst acks=%0d done=%0d want 3 16", acks, dc); end
    total++;
    if (mem[64] !== 32'h1234_5678) begin bad++; $display("FAIL starve_cpu_store got=%h want=12345678", mem[64]); end
  endtask

  task automatic test_wrap();
    int acks, dc;
    mem[1023] = 32'h1111_1023; mem[0] = 32'h1111_0000; mem[1] = 32'h1111_0001;
    run_dma(1'b0, 32'hFFC, 3, 1'b0, 1'b0, acks, dc);
    total++;
    if (acks != 3 || dc != 4) begin bad++; $display("FAIL wrap_burst acks=%0d done=%0d want 3 4", acks, dc); end
  endtask

  task automatic test_zero_len();
    int acks, dc;
    mem[32] = 32'h7777_7777;
    run_dma(1'b1, 32'h80, 0, 1'b0, 1'b0, acks, dc);
    total++;
    if (acks != 0 || dc != 1 || mem[32] !== 32'h7777_7777) begin
      bad++; $display("FAIL zero_len acks=%0d done=%0d word=%h want 0 1 77777777", acks, dc, mem[32]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int acks = 0;
    beat_t e;
    for (int i = 0; i < 5; i++) mem[i] = 32'h5A5A_0000 + i;
    for (int i = 0; i < 2; i++) begin
      e.addr = 32'(i * 4); e.we = 1'b1; e.data = 32'hA000_0000 + i; q.push_back(e);
    end
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_len = 8'd5; dma_wdata = 32'hA000_0000;
    @(posedge clk); #1;
    dma_req = 1'b0;
    for (int c = 0; c < 10 && acks < 2; c++) begin
      @(negedge clk);
      if (dma_ack) begin
        e = q.pop_front();
        total++;
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          bad++; $display("FAIL rst_beat addr=%h data=%h want addr=%h data=%h", mem_addr, mem_wdata, e.addr, e.data);
        end
        acks++;
      end
      @(posedge clk); #1;
      dma_wdata = 32'hA000_0000 + acks;
    end
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hFFFF_FFFF;
    #1;
    total++;
    if ({cpu_stall, dma_ack, dma_done, dma_busy, mem_wr} !== 5'b0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b want=00000", {cpu_stall, dma_ack, dma_done, dma_busy, mem_wr});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (dma_done !== 1'b0 || dma_ack !== 1'b0) begin
        bad++; $display("FAIL rst_no_resume done=%b ack=%b want 0 0", dma_done, dma_ack);
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem[i] !== (i < 2 ? 32'hA000_0000 + i : 32'h5A5A_0000 + i)) begin
        bad++; $display("FAIL rst_word%0d got=%h want=%h", i, mem[i], i < 2 ? 32'hA000_0000 + i : 32'h5A5A_0000 + i);
      end
    end
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_cpu_only();
    test_dma_write();
    test_starvation();
    test_wrap();
    test_zero_len();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
